// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: loadable instruction memory for the ARM-subset core.
// A loader streams a program image in over a valid/ready port. The core then
// fetches words through a fully pipelined port with one cycle of latency.
// Fetches of words that were never loaded return NOP_WORD. Misaligned or
// out-of-range fetches raise fetch_fault.
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit with
// each word. A parity mismatch on fetch is then reported on the extra
// fetch_perr port.
module instr_mem_loadable #(
  parameter int          WIDTH    = 32,
  parameter int          DEPTH    = 128,
  parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [WIDTH-1:0]       load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic                   load_done,
  output logic                   busy,
  input  logic                   fetch_req,
  input  logic [31:0]            fetch_addr,
  output logic                   fetch_valid,
  output logic [WIDTH-1:0]       fetch_data,
  output logic                   fetch_fault,
`ifdef IMEM_PARITY_EN
  output logic                   fetch_perr,
`endif
  output logic [$clog2(DEPTH):0] word_count
);

  localparam int OFS = $clog2(WIDTH / 8);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] NOP     = WIDTH'(NOP_WORD);
  localparam logic [AW:0]      LAST_WP = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0]      ONE     = (AW + 1)'(1);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t           state;
  logic [AW:0]      wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             complete;
  logic             addr_fault;
  logic             unloaded;
  logic             fetch_go;
  logic [AW-1:0]    index;
  logic             par_bad;

  // A restart in the same cycle as an offered word drops that word.
  assign accept     = load_valid && load_ready && !load_start;
  assign complete   = accept && (load_last || (wr_ptr == LAST_WP));
  assign addr_fault = (fetch_addr[OFS-1:0] != '0) || (fetch_addr[31:OFS+AW] != '0);
  assign index      = fetch_addr[OFS+AW-1:OFS];
  assign unloaded   = {1'b0, index} >= word_count;
  // A load request takes priority over a fetch issued in the same cycle.
  assign fetch_go   = fetch_req && (state == RUN) && !load_start;
  assign busy       = (state != RUN);

`ifdef IMEM_PARITY_EN
  logic [DEPTH-1:0] mem_par;

  // Store even parity beside each accepted word; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && !reset) mem_par[wr_ptr[AW-1:0]] <= ^load_data;
  end

  assign par_bad = (^mem[index]) != mem_par[index];
`else
  assign par_bad = 1'b0;
`endif

  // Write accepted image words; the array is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (accept && !reset) mem[wr_ptr[AW-1:0]] <= load_data;
  end

  // Load sequencing, registered handshake outputs and the fetch pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      wr_ptr      <= '0;
      word_count  <= '0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data  <= NOP;
      fetch_fault <= 1'b0;
`ifdef IMEM_PARITY_EN
      fetch_perr  <= 1'b0;
`endif
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state      <= LOAD;
        wr_ptr     <= '0;
        word_count <= '0;
        load_ready <= 1'b1;
      end else if (complete) begin
        state      <= RUN;
        wr_ptr     <= wr_ptr + ONE;
        word_count <= wr_ptr + ONE;
        load_ready <= 1'b0;
        load_done  <= 1'b1;
      end else if (accept) begin
        wr_ptr     <= wr_ptr + ONE;
        word_count <= wr_ptr + ONE;
      end

      fetch_valid <= fetch_go;
`ifdef IMEM_PARITY_EN
      fetch_perr  <= fetch_go && !addr_fault && !unloaded && par_bad;
`endif
      if (fetch_go) begin
        if (addr_fault) begin
          fetch_fault <= 1'b1;
          fetch_data  <= NOP;
        end else if (unloaded) begin
          fetch_fault <= 1'b0;
          fetch_data  <= NOP;
        end else if (par_bad) begin
          fetch_fault <= 1'b1;
          fetch_data  <= NOP;
        end else begin
          fetch_fault <= 1'b0;
          fetch_data  <= mem[index];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: randomized bench for instr_mem_loadable.
// An image queue models the memory contents, and the outputs are predicted
// from it each cycle. Directed literal checks pin that prediction.
module tb_instr_mem_loadable;

  localparam int          DEPTH = 128;
  localparam logic [31:0] NOP   = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        busy;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_fault;
  logic [7:0]  word_count;
`ifdef IMEM_PARITY_EN
  logic        fetch_perr;
`endif

  instr_mem_loadable #(.WIDTH(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .busy        (busy),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_fault (fetch_fault),
`ifdef IMEM_PARITY_EN
    .fetch_perr  (fetch_perr),
`endif
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // Reference model state: the loaded image as a queue plus two mode flags.
  logic [31:0] image[$];
  bit          in_load, running;
  bit          exp_ready, exp_done, exp_fv, exp_ff;
  logic [31:0] exp_fd;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit ls, input bit lv, input logic [31:0] ld, input bit ll,
                               input bit fr, input logic [31:0] fa);
    load_start = ls;
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    fetch_req  = fr;
    fetch_addr = fa;
    @(negedge clk);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(3))
      0, 1:    return 32'($urandom_range(DEPTH - 1)) * 4;
      2:       return 32'($urandom_range(4 * DEPTH + 64));
      default: return $urandom;
    endcase
  endfunction

  // Predict the registered outputs that result from this edge's inputs.
  always @(posedge clk) begin : model
    if (reset) begin
      image.delete();
      in_load   <= 1'b0;
      running   <= 1'b0;
      exp_ready <= 1'b0;
      exp_done  <= 1'b0;
      exp_fv    <= 1'b0;
      exp_fd    <= NOP;
      exp_ff    <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (running && fetch_req && !load_start) begin
        exp_fv <= 1'b1;
        if ((fetch_addr % 4 != 0) || (fetch_addr / 4 >= DEPTH)) begin
          exp_ff <= 1'b1;
          exp_fd <= NOP;
        end else begin
          exp_ff <= 1'b0;
          exp_fd <= (fetch_addr / 4 < image.size()) ? image[fetch_addr / 4] : NOP;
        end
      end else begin
        exp_fv <= 1'b0;
      end
      if (load_start) begin
        image.delete();
        in_load   <= 1'b1;
        running   <= 1'b0;
        exp_ready <= 1'b1;
      end else if (in_load && load_valid) begin
        if (load_last || image.size() == DEPTH - 1) begin
          in_load   <= 1'b0;
          running   <= 1'b1;
          exp_ready <= 1'b0;
          exp_done  <= 1'b1;
        end
        image.push_back(load_data);
      end
    end
  end

  // Compare every output against the model once per cycle, away from the edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("load_ready", load_ready, exp_ready);
      checkOutput("load_done", load_done, exp_done);
      checkOutput("busy", busy, !running);
      checkOutput("word_count", word_count, 64'(image.size()));
      checkOutput("fetch_valid", fetch_valid, exp_fv);
      checkOutput("fetch_data", fetch_data, exp_fd);
      checkOutput("fetch_fault", fetch_fault, exp_ff);
`ifdef IMEM_PARITY_EN
      checkOutput("fetch_perr", fetch_perr, 1'b0);
`endif
    end
  end

  initial begin
    reset = 1'b1;
    load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    fetch_req = 0; fetch_addr = 0;
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_fetch_data", fetch_data, NOP);
    checkOutput("rst_word_count", word_count, 0);
    reset = 1'b0;

    // Fetch while empty is ignored.
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("t1_fetch_valid", fetch_valid, 0);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_fetch_data", fetch_data, NOP);

    // Three-word image followed by back-to-back fetches.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t2_ready_after_start", load_ready, 1);
    applyStimulus(0, 1, 32'hE3A01007, 0, 0, 0);
    applyStimulus(0, 1, 32'hE3A02002, 0, 0, 0);
    applyStimulus(0, 1, 32'hE1A03231, 1, 0, 0);
    checkOutput("t2_load_done", load_done, 1);
    checkOutput("t2_word_count", word_count, 3);
    checkOutput("t2_busy", busy, 0);
    checkOutput("t2_ready_off", load_ready, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("t2_fetch0", fetch_data, 32'hE3A01007);
    applyStimulus(0, 0, 0, 0, 1, 4);
    checkOutput("t2_fetch4", fetch_data, 32'hE3A02002);
    applyStimulus(0, 0, 0, 0, 1, 8);
    checkOutput("t2_fetch8", fetch_data, 32'hE1A03231);
    checkOutput("t2_fetch8_valid", fetch_valid, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_idle_valid", fetch_valid, 0);
    checkOutput("t2_idle_hold", fetch_data, 32'hE1A03231);
    checkOutput("t2_done_once", load_done, 0);

    // Unloaded, misaligned and out-of-range fetches.
    applyStimulus(0, 0, 0, 0, 1, 32'h0C);
    checkOutput("t3_unloaded_data", fetch_data, NOP);
    checkOutput("t3_unloaded_fault", fetch_fault, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h06);
    checkOutput("t3_misaligned_fault", fetch_fault, 1);
    checkOutput("t3_misaligned_data", fetch_data, NOP);
    applyStimulus(0, 0, 0, 0, 1, 4 * DEPTH);
    checkOutput("t3_range_fault", fetch_fault, 1);

    // Random fetches against the short image; stray load_valid is ignored.
    for (int i = 0; i < 150; i++)
      applyStimulus(0, $urandom_range(1) == 1, $urandom, $urandom_range(1) == 1,
                    $urandom_range(3) != 0, randAddr());

    // Full-depth load without load_last; the word offered with load_start is dropped.
    applyStimulus(1, 1, $urandom, 0, 0, 0);
    for (int i = 0; i < 1000 && !running; i++)
      applyStimulus(0, $urandom_range(3) != 0, $urandom, 0, $urandom_range(1) == 1, randAddr());
    checkOutput("t4_load_done", load_done, 1);
    checkOutput("t4_word_count", word_count, DEPTH);
    checkOutput("t4_busy", busy, 0);
    for (int i = 0; i < 200; i++)
      applyStimulus(0, 0, 0, 0, $urandom_range(3) != 0, randAddr());

    // Reset part-way through a load, then a clean reload with a restart inside LOAD.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h11111111, 0, 0, 0);
    applyStimulus(0, 1, 32'h22222222, 0, 0, 0);
    checkOutput("t5_partial_count", word_count, 2);
    reset = 1'b1;
    applyStimulus(0, 1, 32'h33333333, 0, 0, 0);
    checkOutput("t5_reset_count", word_count, 0);
    checkOutput("t5_reset_busy", busy, 1);
    checkOutput("t5_reset_ready", load_ready, 0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h44444444, 0, 0, 0);
    applyStimulus(1, 1, 32'h55555555, 0, 0, 0);
    checkOutput("t5_restart_count", word_count, 0);
    checkOutput("t5_restart_ready", load_ready, 1);
    applyStimulus(0, 1, 32'hCAFE0001, 1, 0, 0);
    checkOutput("t5_reload_count", word_count, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("t5_fetch0", fetch_data, 32'hCAFE0001);

    // A load request beats a simultaneous fetch.
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("t6_fetch_valid", fetch_valid, 0);
    checkOutput("t6_load_ready", load_ready, 1);
    checkOutput("t6_busy", busy, 1);
    applyStimulus(0, 1, 32'h0BADF00D, 1, 0, 0);

    // Mixed random traffic including restarts and occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(199) == 0);
      applyStimulus($urandom_range(39) == 0, $urandom_range(2) != 0, $urandom,
                    $urandom_range(7) == 0, $urandom_range(1) == 1, randAddr());
    end
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised, loadable instruction memory for the ARM-subset processor core.
- Replaces the fixed, combinationally read program store.
- A program loader (UART/JTAG bridge) streams the image in through a valid/ready port.
- The core then fetches instruction words with 1-cycle registered latency.
- Fetches of unloaded words return a NOP; illegal addresses raise a fault.

Parameters:
WIDTH, 32, instruction word width in bits; legal values 32 or 64; OFS = log2(WIDTH/8) byte-offset bits.
DEPTH, 128, number of words; power of two; AW = log2(DEPTH).
NOP_WORD, 32'hE1A00000, value returned for unloaded, faulting or ignored fetches (MOV R0,R0); zero-extended when WIDTH=64.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
load_start  input  1  single-cycle pulse; enter LOAD and rewind the write pointer.
load_valid  input  1  load_data is valid.
load_data  input  WIDTH  program word.
load_last  input  1  qualifies the final word of the image.
load_ready  output  1  memory accepts a word this cycle.
load_done  output  1  one-cycle pulse when the image is complete.
busy  output  1  high whenever state != RUN.
fetch_req  input  1  fetch request, sampled every cycle.
fetch_addr  input  32  byte address of the requested instruction.
fetch_valid  output  1  fetch_data/fetch_fault valid this cycle.
fetch_data  output  WIDTH  fetched word.
fetch_fault  output  1  misaligned or out-of-range fetch.
word_count  output  AW+1  number of words loaded.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- States: EMPTY (reset state, no image), LOAD, RUN.
- Reset values:
  - state=EMPTY, wr_ptr=0, word_count=0.
  - load_ready=0, load_done=0, busy=1.
  - fetch_valid=0, fetch_data=NOP_WORD, fetch_fault=0.
  - Array contents are not cleared.
- Reset mid-load or mid-fetch: same result as reset. The partial image is discarded; word_count=0.
- EMPTY or RUN + load_start -> LOAD, with wr_ptr=0 and word_count=0.
- load_ready is a registered output: 1 exactly while state=LOAD. It is 0 in the cycle load_start is sampled and 1 from the next cycle.
- load_start while in LOAD: wr_ptr rewinds to 0, and any word offered that cycle is dropped.
- Accept = load_valid & load_ready. On accept:
  - mem[wr_ptr] <= load_data; wr_ptr++.
  - word_count <= wr_ptr+1.
- Image completion: an accepted word with load_last=1, or an accepted word at wr_ptr=DEPTH-1 (auto-terminate, word_count=DEPTH).
  - On completion: -> RUN, load_done=1 for exactly one cycle, load_ready=0 the next cycle.
- load_valid outside LOAD is ignored.
- Fetch is active only in RUN. With fetch_req=1 in cycle N, the result appears in cycle N+1 with fetch_valid=1.
  - Fully pipelined: one request per cycle, no stalls.
- Fetch result priority for the request in cycle N:
  - fetch_addr[OFS-1:0] != 0, or fetch_addr[31:OFS] >= DEPTH: fetch_fault=1, fetch_data=NOP_WORD.
  - Else index = fetch_addr[OFS+AW-1:OFS]. If index >= word_count: fetch_data=NOP_WORD, fetch_fault=0.
  - Else fetch_data=mem[index], fetch_fault=0.
- fetch_req outside RUN: fetch_valid=0 next cycle, and fetch_data/fetch_fault hold.
- Simultaneous load_start and fetch_req in RUN: load wins, the fetch is dropped, and fetch_valid=0 next cycle.
- Fetch of an address written in the same cycle: impossible by construction, since LOAD and RUN are exclusive.
- fetch_valid=0 cycles: fetch_data and fetch_fault hold their last values.
- Arithmetic: wr_ptr is AW+1 bits, so no wrap is possible. word_count saturates at DEPTH.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from load_data on accept.
  - On fetch, parity is recomputed. A mismatch on a loaded, in-range word forces fetch_data=NOP_WORD and fetch_fault=1.
  - An extra output port fetch_perr (1 bit) pulses with the affected fetch_valid. fetch_perr resets to 0.
- Not defined: no parity storage, no fetch_perr port, and fault is address-only.

Test Plan:
1. Reset, then fetch_req with fetch_addr=0 -> fetch_valid stays 0 next cycle; busy=1, fetch_data=NOP_WORD.
2. Load image.
   - Stimulus: load_start, then E3A01007, E3A02002, E1A03231 (last=1), fetch addresses 0, 4, 8 on back-to-back cycles.
   - Response: load_done pulses once and word_count=3. Fetches return E3A01007, E3A02002, E1A03231 on 3 consecutive cycles, each 1 cycle after its request.
3. After loading 3 words, fetch addr 0x0C -> E1A00000, fault=0. Fetch addr 0x06 -> fault=1, data=E1A00000. Fetch addr 4*DEPTH -> fault=1.
4. Load DEPTH words with load_last never asserted -> auto-terminate at word DEPTH-1: load_done=1, word_count=DEPTH, busy=0.
5. Asserting reset after 2 of 5 load words -> state EMPTY and word_count=0. A new load_start reloads cleanly, and fetch addr 0 returns the new word.
6. Simultaneous load_start and fetch_req in RUN -> fetch_valid=0 next cycle, load_ready=1, busy=1.
